// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first word serializer with optional even parity, idle gap and word counter
module serial_word_tx #(
    parameter int WIDTH  = 8,
    parameter int PARITY = 0,
    parameter int GAP    = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             frame_start,
    output logic [CNT_W-1:0] words_sent
);
    localparam int L  = WIDTH + PARITY;
    localparam int BW = $clog2(L);
    localparam logic [BW-1:0] LAST_BIT  = BW'(L - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [3:0]    LAST_GAP  = 4'(GAP > 0 ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               tx_bit_q, tx_bit_d;
    logic               tx_active_q, tx_active_d;
    logic               frame_start_q, frame_start_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               last_bit, last_gap, accept;

    assign tx_bit      = tx_bit_q;
    assign tx_active   = tx_active_q;
    assign frame_start = frame_start_q;
    assign words_sent  = words_q;

    // Next-state logic: the bit shown next cycle is prepared here, so outputs stay registered
    always_comb begin
        last_bit      = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
        last_gap      = (state_q == S_GAP) && (gap_cnt_q == LAST_GAP);
        load_ready    = (state_q == S_IDLE) || ((GAP == 0) && last_bit) || ((GAP > 0) && last_gap);
        accept        = load_valid && load_ready;
        state_d       = state_q;
        shift_d       = shift_q;
        par_d         = par_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        tx_bit_d      = 1'b0;
        tx_active_d   = 1'b0;
        frame_start_d = 1'b0;
        words_d       = words_q + {{(CNT_W-1){1'b0}}, last_bit};
        if (accept) begin
            state_d       = S_SHIFT;
            shift_d       = {data_in[WIDTH-2:0], 1'b0};
            par_d         = ^data_in;
            bit_cnt_d     = '0;
            tx_bit_d      = data_in[WIDTH-1];
            tx_active_d   = 1'b1;
            frame_start_d = 1'b1;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        shift_d     = {shift_q[WIDTH-2:0], 1'b0};
                        tx_bit_d    = (PARITY != 0 && bit_cnt_q == LAST_DATA) ? par_q : shift_q[WIDTH-1];
                        tx_active_d = 1'b1;
                    end else if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (last_gap) state_d = S_IDLE;
                    else gap_cnt_d = gap_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset aborts any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            par_q         <= 1'b0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            tx_bit_q      <= 1'b0;
            tx_active_q   <= 1'b0;
            frame_start_q <= 1'b0;
            words_q       <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_active_q   <= tx_active_d;
            frame_start_q <= frame_start_d;
            words_q       <= words_d;
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed checks of serial_word_tx in three parameter configurations
module tb_serial_word_tx;
    logic clk, rst;
    logic v0, v1, v2;
    logic [7:0] d0, d1, d2;
    logic r0, b0, a0, f0, r1, b1, a1, f1, r2, b2, a2, f2;
    logic [7:0] w0, w2;
    logic [3:0] w1;
    logic [7:0] e8;
    logic [8:0] e9;
    int checks = 0;
    int errors = 0;

    serial_word_tx u0 (.clk(clk), .rst(rst), .data_in(d0), .load_valid(v0), .load_ready(r0),
                       .tx_bit(b0), .tx_active(a0), .frame_start(f0), .words_sent(w0));
    serial_word_tx #(.WIDTH(8), .PARITY(0), .GAP(0), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .data_in(d1),
                       .load_valid(v1), .load_ready(r1), .tx_bit(b1), .tx_active(a1), .frame_start(f1),
                       .words_sent(w1));
    serial_word_tx #(.WIDTH(8), .PARITY(1), .GAP(1), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .data_in(d2),
                       .load_valid(v2), .load_ready(r2), .tx_bit(b2), .tx_active(a2), .frame_start(f2),
                       .words_sent(w2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; v0 = 0; v1 = 0; v2 = 0; d0 = 0; d1 = 0; d2 = 0;
        tick; tick;
        chk("rst_bit", b0, 0); chk("rst_active", a0, 0); chk("rst_frame", f0, 0);
        chk("rst_ready", r0, 1); chk("rst_words", w0, 0); chk("rst_words1", w1, 0);
        rst = 1'b0;
        e8 = 8'hA5; d0 = 8'hA5; v0 = 1; tick; v0 = 0; d0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", b0, e8[7-i]); chk("a5_active", a0, 1);
            chk("a5_frame", f0, i == 0); chk("a5_ready", r0, 0);
            tick;
        end
        chk("a5_gap_bit", b0, 0); chk("a5_gap_active", a0, 0); chk("a5_gap_ready", r0, 1); chk("a5_words", w0, 1);
        tick;
        chk("a5_idle_active", a0, 0);
        d0 = 8'hA5; v0 = 1; tick; v0 = 0;
        for (int i = 0; i < 8; i++) begin
            chk("drop_bit", b0, e8[7-i]);
            if (i == 3) begin v0 = 1; d0 = 8'h3C; end else v0 = 0;
            tick;
        end
        chk("drop_words", w0, 2); chk("drop_gap_active", a0, 0);
        tick; chk("drop_idle_active", a0, 0);
        tick; chk("drop_idle_active2", a0, 0); chk("drop_words2", w0, 2);
        d1 = 8'hFF; v1 = 1; tick; d1 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_active", a1, 1); chk("b2b_bit", b1, i < 8);
            chk("b2b_frame", f1, i == 0 || i == 8); chk("b2b_ready", r1, i == 7 || i == 15);
            if (i >= 8) v1 = 0;
            tick;
        end
        chk("b2b_after_active", a1, 0); chk("b2b_words", w1, 2); chk("b2b_after_ready", r1, 1);
        d1 = 8'h5A; v1 = 1; tick;
        repeat (96) tick;
        v1 = 0;
        repeat (8) tick;
        chk("wrap_words15", w1, 15); chk("wrap_active", a1, 0);
        v1 = 1; tick; v1 = 0;
        repeat (8) tick;
        chk("wrap_words0", w1, 0);
        e9 = 9'b000001111; d2 = 8'h07; v2 = 1; tick; v2 = 0;
        for (int i = 0; i < 9; i++) begin
            chk("par07_bit", b2, e9[8-i]); chk("par07_active", a2, 1); chk("par07_frame", f2, i == 0);
            tick;
        end
        chk("par07_gap_active", a2, 0); chk("par07_words", w2, 1);
        tick;
        e9 = 9'b000000110; d2 = 8'h03; v2 = 1; tick; v2 = 0;
        for (int i = 0; i < 9; i++) begin
            chk("par03_bit", b2, e9[8-i]); chk("par03_active", a2, 1);
            tick;
        end
        chk("par03_gap_active", a2, 0); chk("par03_words", w2, 2);
        tick;
        d0 = 8'hF0; v0 = 1; tick; v0 = 0;
        chk("abort_bit1", b0, 1); tick;
        chk("abort_bit2", b0, 1); tick;
        chk("abort_bit3", b0, 1); chk("abort_active3", a0, 1);
        rst = 1; tick; rst = 0;
        chk("abort_active", a0, 0); chk("abort_bit", b0, 0); chk("abort_frame", f0, 0);
        chk("abort_words", w0, 0); chk("abort_ready", r0, 1);
        e8 = 8'hF0; d0 = 8'hF0; v0 = 1; tick; v0 = 0;
        for (int i = 0; i < 8; i++) begin
            chk("resend_bit", b0, e8[7-i]); chk("resend_active", a0, 1);
            tick;
        end
        chk("resend_words", w0, 1); chk("resend_gap_active", a0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
